secded_decode_pipe: RTL and testbench
=====================================

Name: secded_decode_pipe

Overview:
Parametrised Hamming SECDED checker/corrector for the memory read path, and the next generation of the combinational 32-bit parity encoder. It recomputes check bits over a received codeword, corrects single-bit errors and flags double-bit errors. It is a 2-stage valid/ready pipeline with saturating error counters and a sticky first-uncorrectable-error log, and sits between the data memory read port and the load/writeback logic.

Parameters:
- DATA_W, 32, data bits per word; minimum 4.
- P_W, derived (localparam), Hamming check-bit count; smallest P with 2^P >= DATA_W+P+1; equals 6 at DATA_W=32.
- TAG_W, 8, sideband tag (e.g. address index) carried alongside each word.
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, stage 1 can accept a word.
- in_data, input, DATA_W, received data bits.
- in_parity, input, P_W, received Hamming check bits.
- in_ded, input, 1, received overall (DED) parity bit.
- in_tag, input, TAG_W, sideband tag.
- out_valid, output, 1, corrected word valid.
- out_ready, input, 1, downstream accepts the word.
- out_data, output, DATA_W, corrected data.
- out_tag, output, TAG_W, tag passed through unchanged.
- out_ce, output, 1, a single error was corrected (or was in check/DED bits only).
- out_ue, output, 1, uncorrectable error; out_data is the raw received data.
- ce_count, output, CNT_W, saturating correctable-error count.
- ue_count, output, CNT_W, saturating uncorrectable-error count.
- ue_log_valid, output, 1, sticky flag: a UE has been logged.
- ue_log_tag, output, TAG_W, tag of the first logged UE.
- ue_log_syn, output, P_W, syndrome of the first logged UE.
- cnt_clr, input, 1, clears both counters and the UE log.

Behaviour:
- Code mapping: codeword positions are numbered from 1. Power-of-two positions hold check bits. Data bit k occupies the k-th non-power-of-two position in ascending order (d0 at pos 3, d1 at pos 5, d2 at pos 6, d3 at pos 7, d4 at pos 9, and so on).
- Check bit i is the XOR of the data bits whose position has bit i set.
- The DED bit is the XOR of all data bits and all check bits.
- Stage 1 (register): syn = recomputed parity XOR in_parity. ovr = XOR of in_data, in_parity and in_ded. in_data and in_tag are also registered.
- Stage 2 (register): classify the word and correct it.
  - syn==0, ovr==0: clean. ce=0, ue=0.
  - ovr==1, syn==0: DED bit error. ce=1, data unchanged.
  - ovr==1, syn is a power of two: check-bit error. ce=1, data unchanged.
  - ovr==1, syn is another value <= DATA_W+P_W: flip the data bit at position syn. ce=1.
  - ovr==1, syn > DATA_W+P_W: ue=1 (multi-bit error), data uncorrected.
  - ovr==0, syn!=0: double error. ue=1, data uncorrected.
- Latency: 2 cycles from accept (in_valid && in_ready) to out_valid, with no stall.
- Throughput: 1 word per cycle.
- Handshake:
  - Each stage holds its contents while its downstream is stalled.
  - in_ready = !s1_valid || (s2 empty or draining), where s2 drains when !out_valid || out_ready. in_ready is combinational from out_ready.
  - out_* stay stable while out_valid && !out_ready.
  - No word is dropped or duplicated.
- Counters:
  - ce_count and ue_count increment only on the output transfer (out_valid && out_ready), by 1 for ce or ue respectively.
  - They saturate at all-ones.
  - If cnt_clr and a counted transfer occur in the same cycle, the counter loads 1. Otherwise cnt_clr loads 0.
- UE log:
  - On the first UE transfer while ue_log_valid==0, capture tag and syndrome and set ue_log_valid.
  - Later UEs do not overwrite the log.
  - cnt_clr clears the log. A UE transfer in the same cycle as cnt_clr is captured (it re-logs).
- Reset: rst clears all valids, out_ce, out_ue, both counters, ue_log_valid, ue_log_tag and ue_log_syn to 0. out_data and out_tag reset to 0. Reset mid-flight discards in-pipeline words silently and is not counted. in_ready reads 1 in the first cycle after reset deasserts.

Optional Feature:
ECC_INJECT_EN
- Defined: adds input inj_mask (DATA_W+P_W+1 bits, ordered {ded, parity, data}). It is XORed into the received codeword before stage 1 for every accepted word, so self-test needs no corrupted memory.
- Undefined: the port is absent and there is no XOR logic; behaviour is otherwise identical.

Decomposition:
- Package ecc_pkg: function ecc_pw(data_w) returning P_W; function ecc_pos(k) returning the codeword position of data bit k; typedef for the status enum (ECC_CLEAN, ECC_CE, ECC_UE).
- One sub-module: secded_parity_gen (DATA_W -> P_W check bits plus overall parity, combinational). It is used for stage 1 here and reused on the write path as the parametrised encoder.

Test Plan (DATA_W=32):
- Clean word: encode 0xDEADBEEF via secded_parity_gen, feed it -> out_data 0xDEADBEEF two cycles later; ce=0, ue=0; counters 0.
- Data single error: flip data bit 5 -> out_data 0xDEADBEEF, out_ce=1, ce_count=1.
- Check-bit or DED-bit single error: flip parity[3], then in_ded -> data unchanged, ce=1 each time, ce_count=2.
- Double error: flip data bits 0 and 31 with tag 0x5A -> out_data raw, ue=1, ue_count=1, ue_log_valid=1, ue_log_tag=0x5A. A second UE with tag 0x77 leaves the log at 0x5A.
- Backpressure: stream 6 words and hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; all 6 words emerge in order, unchanged, with no duplicates.
- Saturation, clear and reset: with CNT_W=4, send 20 CE words -> ce_count=15. Then cnt_clr together with a CE transfer -> ce_count=1. Then assert rst with 2 words in flight -> out_valid=0 next cycle and counters 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared Hamming SECDED helpers: check-bit count, data-bit position map and
// the per-word status encoding used by the decode pipeline.
package ecc_pkg;

  typedef enum logic [1:0] {
    ECC_CLEAN = 2'd0,
    ECC_CE    = 2'd1,
    ECC_UE    = 2'd2
  } ecc_status_e;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int ecc_pw(input int data_w);
    int p;
    p = 0;
    for (int q = 1; q < 31; q++)
      if (p == 0 && (1 << q) >= data_w + q + 1) p = q;
    return p;
  endfunction

  // Codeword position (1-based) of data bit k: k-th non-power-of-two slot.
  function automatic int ecc_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int q = 3; q < k + 40; q++)
      if (pos == 0 && (q & (q - 1)) != 0) begin
        if (cnt == k) pos = q;
        cnt++;
      end
    return pos;
  endfunction

endpackage

// File: rtl/secded_parity_gen.sv
// Combinational Hamming check-bit generator plus overall parity; serves as the
// write-path encoder and as the recompute stage of the read-path decoder.
module secded_parity_gen
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int P_W    = ecc_pw(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [P_W-1:0]    o_parity,
  output logic              o_ded
);

  for (genvar i = 0; i < P_W; i++) begin : g_chk
    logic [DATA_W-1:0] w_sel;
    for (genvar k = 0; k < DATA_W; k++) begin : g_bit
      localparam int POS = ecc_pos(k);
      assign w_sel[k] = POS[i] ? i_data[k] : 1'b0;
    end
    assign o_parity[i] = ^w_sel;
  end

  assign o_ded = (^i_data) ^ (^o_parity);

endmodule

// File: rtl/secded_decode_pipe.sv
// Two-stage valid/ready SECDED checker/corrector with saturating error counters
// and a sticky first-UE log. Define ECC_INJECT_EN to add the inj_mask self-test port.
module secded_decode_pipe
  import ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int TAG_W  = 8,
  parameter  int CNT_W  = 16,
  localparam int P_W    = ecc_pw(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [P_W-1:0]       in_parity,
  input  logic                 in_ded,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef ECC_INJECT_EN
  input  logic [DATA_W+P_W:0]  inj_mask,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_ce,
  output logic                 out_ue,
  output logic [CNT_W-1:0]     ce_count,
  output logic [CNT_W-1:0]     ue_count,
  output logic                 ue_log_valid,
  output logic [TAG_W-1:0]     ue_log_tag,
  output logic [P_W-1:0]       ue_log_syn,
  input  logic                 cnt_clr
);

  localparam logic [P_W-1:0]   MAX_POS = P_W'(DATA_W + P_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] w_rx_data;
  logic [P_W-1:0]    w_rx_par;
  logic              w_rx_ded;
  logic [P_W-1:0]    w_gen_par;
  logic              w_gen_ded;
  logic [P_W-1:0]    w_syn;
  logic              w_s2_drain, w_in_fire, w_out_fire;

  logic              r_s1_vld, r_s1_ovr;
  logic [P_W-1:0]    r_s1_syn;
  logic [DATA_W-1:0] r_s1_data;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_vld, r_out_ce, r_out_ue;
  logic [DATA_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;
  logic [P_W-1:0]    r_s2_syn;

  logic [CNT_W-1:0]  r_ce_cnt, r_ue_cnt;
  logic              r_log_vld;
  logic [TAG_W-1:0]  r_log_tag;
  logic [P_W-1:0]    r_log_syn;

`ifdef ECC_INJECT_EN
  assign w_rx_data = in_data   ^ inj_mask[DATA_W-1:0];
  assign w_rx_par  = in_parity ^ inj_mask[DATA_W+P_W-1:DATA_W];
  assign w_rx_ded  = in_ded    ^ inj_mask[DATA_W+P_W];
`else
  assign w_rx_data = in_data;
  assign w_rx_par  = in_parity;
  assign w_rx_ded  = in_ded;
`endif

  secded_parity_gen #(.DATA_W(DATA_W)) u_gen (
    .i_data   (w_rx_data),
    .o_parity (w_gen_par),
    .o_ded    (w_gen_ded)
  );

  // gen_ded ^ ^syn folds to ^data ^ ^rx_parity, so adding rx_ded yields the overall check.
  assign w_syn      = w_gen_par ^ w_rx_par;
  assign w_s2_drain = !r_s2_vld || out_ready;
  assign in_ready   = !r_s1_vld || w_s2_drain;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_vld && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_ovr  <= 1'b0;
      r_s1_syn  <= '0;
      r_s1_data <= '0;
      r_s1_tag  <= '0;
    end else if (w_in_fire) begin
      r_s1_vld  <= 1'b1;
      r_s1_syn  <= w_syn;
      r_s1_ovr  <= w_gen_ded ^ (^w_syn) ^ w_rx_ded;
      r_s1_data <= w_rx_data;
      r_s1_tag  <= in_tag;
    end else if (w_s2_drain) begin
      r_s1_vld  <= 1'b0;
    end
  end

  // One-hot flip vector: only a syndrome equal to a data position selects a bit.
  logic [DATA_W-1:0] w_flip;
  for (genvar k = 0; k < DATA_W; k++) begin : g_flip
    localparam logic [P_W-1:0] POS = P_W'(ecc_pos(k));
    assign w_flip[k] = (r_s1_syn == POS);
  end

  ecc_status_e       w_status;
  logic [DATA_W-1:0] w_fix;

  always_comb begin
    w_status = ECC_CLEAN;
    w_fix    = r_s1_data;
    if (r_s1_ovr) begin
      if (r_s1_syn > MAX_POS) begin
        w_status = ECC_UE;
      end else begin
        w_status = ECC_CE;
        w_fix    = r_s1_data ^ w_flip;
      end
    end else if (r_s1_syn != '0) begin
      w_status = ECC_UE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld   <= 1'b0;
      r_out_ce   <= 1'b0;
      r_out_ue   <= 1'b0;
      r_out_data <= '0;
      r_out_tag  <= '0;
      r_s2_syn   <= '0;
    end else if (w_s2_drain) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out_ce   <= (w_status == ECC_CE);
        r_out_ue   <= (w_status == ECC_UE);
        r_out_data <= w_fix;
        r_out_tag  <= r_s1_tag;
        r_s2_syn   <= r_s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
    end else begin
      if (cnt_clr)
        r_ce_cnt <= (w_out_fire && r_out_ce) ? CNT_W'(1) : '0;
      else if (w_out_fire && r_out_ce && r_ce_cnt != CNT_MAX)
        r_ce_cnt <= r_ce_cnt + CNT_W'(1);
      if (cnt_clr)
        r_ue_cnt <= (w_out_fire && r_out_ue) ? CNT_W'(1) : '0;
      else if (w_out_fire && r_out_ue && r_ue_cnt != CNT_MAX)
        r_ue_cnt <= r_ue_cnt + CNT_W'(1);
    end
  end

  // A UE arriving with the clear re-arms the log with that word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_log_vld <= 1'b0;
      r_log_tag <= '0;
      r_log_syn <= '0;
    end else if (w_out_fire && r_out_ue && (cnt_clr || !r_log_vld)) begin
      r_log_vld <= 1'b1;
      r_log_tag <= r_out_tag;
      r_log_syn <= r_s2_syn;
    end else if (cnt_clr) begin
      r_log_vld <= 1'b0;
      r_log_tag <= '0;
      r_log_syn <= '0;
    end
  end

  assign out_valid    = r_s2_vld;
  assign out_data     = r_out_data;
  assign out_tag      = r_out_tag;
  assign out_ce       = r_out_ce;
  assign out_ue       = r_out_ue;
  assign ce_count     = r_ce_cnt;
  assign ue_count     = r_ue_cnt;
  assign ue_log_valid = r_log_vld;
  assign ue_log_tag   = r_log_tag;
  assign ue_log_syn   = r_log_syn;

endmodule

// File: tb/tb_secded_decode_pipe.sv
// Scoreboard bench for secded_decode_pipe (DATA_W=32, CNT_W=4): directed
// single/double/triple error vectors, backpressure, saturation, clear and reset.
module tb_secded_decode_pipe;

  localparam int DW = 32;
  localparam int PW = 6;
  localparam int TW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [PW-1:0] in_parity = '0;
  logic          in_ded = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_ce, out_ue;
  logic [CW-1:0] ce_count, ue_count;
  logic          ue_log_valid;
  logic [TW-1:0] ue_log_tag;
  logic [PW-1:0] ue_log_syn;
  logic          cnt_clr = 1'b0;
`ifdef ECC_INJECT_EN
  logic [DW+PW:0] inj_mask = '0;
`endif

  always #5 clk = ~clk;

  secded_decode_pipe #(.DATA_W(DW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .in_ded(in_ded), .in_tag(in_tag),
`ifdef ECC_INJECT_EN
    .inj_mask(inj_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_ce(out_ce), .out_ue(out_ue),
    .ce_count(ce_count), .ue_count(ue_count),
    .ue_log_valid(ue_log_valid), .ue_log_tag(ue_log_tag), .ue_log_syn(ue_log_syn),
    .cnt_clr(cnt_clr)
  );

  // Standalone encoder instance, compared against the bench's own model.
  logic [DW-1:0] g_data = '0;
  logic [PW-1:0] g_par;
  logic          g_ded;
  secded_parity_gen #(.DATA_W(DW)) u_enc (.i_data(g_data), .o_parity(g_par), .o_ded(g_ded));

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    logic          ce;
    logic          ue;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   accepts = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Check bits = XOR of the positions of all set data bits; codeword {ded, parity, data}.
  function automatic logic [DW+PW:0] enc(input logic [DW-1:0] d);
    logic [PW-1:0] acc;
    logic [31:0]   q32;
    int            c;
    acc = '0;
    c = 0;
    for (int q = 1; q <= DW + PW; q++)
      if ((q & (q - 1)) != 0) begin
        q32 = q;
        if (d[c]) acc ^= q32[PW-1:0];
        c++;
      end
    return {(^d) ^ (^acc), acc, d};
  endfunction

  function automatic logic [DW+PW:0] bitm(input int b);
    logic [DW+PW:0] one;
    one = 1;
    return one << b;
  endfunction

  task automatic send(input logic [DW+PW:0] cw, input logic [TW-1:0] tag,
                      input logic [DW-1:0] exp_d, input logic ce, input logic ue);
    int   n;
    exp_t e;
    in_data = cw[DW-1:0];
    in_parity = cw[DW+PW-1:DW];
    in_ded = cw[DW+PW];
    in_tag = tag;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    else begin
      e.d = exp_d; e.t = tag; e.ce = ce; e.ue = ue;
      sb.push_back(e);
      accepts++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_flip(input logic [DW-1:0] d, input logic [DW+PW:0] flip,
                           input logic [TW-1:0] tag, input logic ce, input logic ue);
    logic [DW+PW:0] cw;
    cw = enc(d) ^ flip;
    send(cw, tag, ue ? cw[DW-1:0] : d, ce, ue);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", (sb.size() == 0 && !out_valid), 1);
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every output transfer and checks held outputs stay stable.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [TW-1:0] hold_t;
  always @(negedge clk) begin
    exp_t e;
    if (hold_v && out_valid)
      chk("hold_stable", {out_ce, out_ue, out_tag, out_data}, {2'b00, hold_t, hold_d} | {out_ce, out_ue, 40'd0});
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_extra", out_valid, 0);
      else begin
        e = sb.pop_front();
        chk("sb_word", {out_ce, out_ue, out_tag, out_data}, {e.ce, e.ue, e.t, e.d});
      end
    end
    hold_v = !rst && out_valid && !out_ready;
    hold_d = out_data;
    hold_t = out_tag;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW+PW:0] ref_cw;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_ce, out_ue, out_tag, out_data}, 0);
    chk("rst_counts", {ce_count, ue_count}, 0);
    chk("rst_log", {ue_log_valid, ue_log_tag, ue_log_syn}, 0);

    g_data = 32'hDEADBEEF;
    #1 ref_cw = enc(32'hDEADBEEF);
    chk("enc_gen", {g_ded, g_par}, ref_cw[DW+PW:DW]);
    @(posedge clk); #1;

    // Clean word and pipeline latency
    send_flip(32'hDEADBEEF, '0, 8'h01, 1'b0, 1'b0);
    chk("lat_s1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_s2", out_valid, 1);
    wait_idle();
    chk("clean_counts", {ce_count, ue_count}, 0);

    send_flip(32'hDEADBEEF, bitm(5), 8'h02, 1'b1, 1'b0);
    wait_idle();
    chk("ce_data_cnt", ce_count, 1);

    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_idle", ce_count, 0);

    send_flip(32'hDEADBEEF, bitm(DW + 3), 8'h03, 1'b1, 1'b0);
    send_flip(32'hDEADBEEF, bitm(DW + PW), 8'h04, 1'b1, 1'b0);
    wait_idle();
    chk("ce_chk_ded_cnt", ce_count, 2);

    // Double error: positions 3 ^ 38 = 37
    send_flip(32'hDEADBEEF, bitm(0) | bitm(31), 8'h5A, 1'b0, 1'b1);
    wait_idle();
    chk("ue_cnt1", ue_count, 1);
    chk("ue_log1", {ue_log_valid, ue_log_tag, ue_log_syn}, {1'b1, 8'h5A, 6'd37});

    send_flip(32'h0BADF00D, bitm(1) | bitm(2), 8'h77, 1'b0, 1'b1);
    // Triple error: 33 ^ 34 ^ 36 = 39, beyond the last position
    send_flip(32'h13572468, bitm(26) | bitm(27) | bitm(29), 8'h33, 1'b0, 1'b1);
    wait_idle();
    chk("ue_cnt3", ue_count, 3);
    chk("ue_log_sticky", {ue_log_valid, ue_log_tag, ue_log_syn}, {1'b1, 8'h5A, 6'd37});

    // Backpressure
    out_ready = 1'b0;
    accepts = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_flip(32'hA5000000 + 32'(i * 7), '0, 8'(8'h40 + i), 1'b0, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepts", accepts, 2);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1 chk("in_ready_comb", in_ready, 1);
      end
    join
    wait_idle();
    chk("bp_total", accepts, 6);
    chk("bp_ce_cnt", ce_count, 2);

    // Saturation: bit 31 (position 38) first, then data/check/DED bits
    for (int i = 0; i < 20; i++)
      send_flip(32'h0F0F0000 + 32'(i), bitm(i == 0 ? 31 : (i * 2) % (DW + PW + 1)), 8'(i), 1'b1, 1'b0);
    wait_idle();
    chk("ce_sat", ce_count, 15);
    chk("ue_hold", ue_count, 3);

    // Clear coinciding with a CE transfer
    send_flip(32'h12345678, bitm(7), 8'hC1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("clr_ce_outv", out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_ce_cnt", {ce_count, ue_count}, {4'd1, 4'd0});
    chk("clr_log", {ue_log_valid, ue_log_tag, ue_log_syn}, 0);

    // Clear coinciding with a UE transfer re-logs: positions 7 ^ 9 = 14
    send_flip(32'h00FF00FF, bitm(3) | bitm(4), 8'h99, 1'b0, 1'b1);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_ue_cnt", {ce_count, ue_count}, {4'd0, 4'd1});
    chk("clr_ue_log", {ue_log_valid, ue_log_tag, ue_log_syn}, {1'b1, 8'h99, 6'd14});

    // Reset with two words in flight
    out_ready = 1'b0;
    send_flip(32'hCAFE0001, bitm(0), 8'hE1, 1'b1, 1'b0);
    send_flip(32'hCAFE0002, bitm(1), 8'hE2, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_outv", out_valid, 0);
    chk("mrst_counts", {ce_count, ue_count}, 0);
    chk("mrst_log", ue_log_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    sb.delete();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_no_out", {out_valid, ce_count}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
